// File: rtl/uart_lcd_feeder_pkg.sv
// Shared constants and types for the UART-to-LCD line feeder: ASCII control codes,
// buffer geometry and the receiver state encoding.
package uart_lcd_feeder_pkg;

  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_FF         = 8'h0C;
  localparam logic [7:0] ASCII_LAST_PRINT = 8'h7E;

  localparam int LINE_CHARS = 6;
  localparam int N_CHARS    = 12;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_SPACE) && (b <= ASCII_LAST_PRINT);
  endfunction

endpackage

// File: rtl/uart_lcd_feeder_rx.sv
// 8N1 UART receiver: two-flop synchroniser, bit timer and framing FSM.
// byte_valid / frame_err are single-cycle strobes in the stop-sample cycle; byte_data is valid with byte_valid.
module uart_rx_core #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);
  import uart_lcd_feeder_pkg::*;

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] FULL_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(DIV / 2 - 1);

  rx_state_e     state_q, state_d;
  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      prev_q    <= 1'b1;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (prev_q && !sync_q) state_d = RX_START;
      RX_START: if (timer_q == HALF_LAST) state_d = sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (timer_q == FULL_LAST && bit_idx_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (timer_q == FULL_LAST) state_d = sync_q ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (sync_q) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    meta_d     = rxd;
    sync_d     = meta_q;
    prev_d     = sync_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      RX_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_idx_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RX_DATA: begin
        if (timer_q == FULL_LAST) begin
          timer_d   = '0;
          shift_d   = {sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RX_STOP: begin
        if (timer_q == FULL_LAST) begin
          timer_d    = '0;
          byte_valid = sync_q;
          frame_err  = !sync_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: timer_d = '0;
    endcase
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/uart_lcd_feeder.sv
// UART receiver feeding a 2x6 character buffer for the LCD text controller.
// Printable bytes are written at wr_ptr; CR, LF and FF move the cursor or clear the screen.
module uart_lcd_feeder #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [95:0] line_data,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_err,
  output logic [3:0]  wr_ptr
);
  import uart_lcd_feeder_pkg::*;

  localparam logic [3:0] PTR_LAST  = 4'(N_CHARS - 1);
  localparam logic [3:0] PTR_LINE1 = 4'(LINE_CHARS);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  uart_rx_core #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  logic [7:0] chars_q [N_CHARS];
  logic [7:0] chars_d [N_CHARS];
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CHARS; i++) chars_q[i] <= ASCII_SPACE;
      wr_ptr_q     <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      chars_q      <= chars_d;
      wr_ptr_q     <= wr_ptr_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Buffer update lands in the same register stage as byte_valid, so both appear together.
  always_comb begin
    chars_d      = chars_q;
    wr_ptr_d     = wr_ptr_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = rx_valid;
    frame_err_d  = rx_err;
    if (rx_valid) begin
      byte_data_d = rx_byte;
      if (is_printable(rx_byte)) begin
        chars_d[wr_ptr_q] = rx_byte;
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? 4'd0 : wr_ptr_q + 4'd1;
      end else begin
        case (rx_byte)
          ASCII_CR: wr_ptr_d = 4'd0;
          ASCII_LF: wr_ptr_d = PTR_LINE1;
          ASCII_FF: begin
            for (int i = 0; i < N_CHARS; i++) chars_d[i] = ASCII_SPACE;
            wr_ptr_d = 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < N_CHARS; gi++) begin : g_pack
    assign line_data[8*gi +: 8] = chars_q[gi];
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign wr_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_uart_lcd_feeder.sv
// Self-checking bench: ideal 8N1 frames, a screen model updated per sent byte,
// and a per-cycle compare process against the DUT outputs.
module tb_uart_lcd_feeder;
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 1_900_000;          // 26.3 -> DIV 26, keeps the run short
  localparam int DIV    = CLK_HZ / BAUD;
  localparam logic [95:0] ALL_SPACES = {12{8'h20}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [95:0] line_data;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        frame_err;
  logic [3:0]  wr_ptr;

  always #10 clk = ~clk;

  uart_lcd_feeder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .line_data (line_data),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .wr_ptr    (wr_ptr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // ---------------- screen model ----------------
  typedef struct {
    logic [7:0]  b;
    logic [95:0] line;
    logic [3:0]  ptr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_chars [12];
  int         m_ptr;
  int         err_exp   = 0;
  int         err_seen  = 0;
  int         valid_cnt = 0;

  function automatic logic [95:0] m_pack();
    logic [95:0] v;
    for (int i = 0; i < 12; i++) v[8*i +: 8] = m_chars[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) m_chars[i] = 8'h20;
    m_ptr = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_chars[m_ptr] = b;
      m_ptr = (m_ptr + 1) % 12;
    end else if (b == 8'h0D) begin
      m_ptr = 0;
    end else if (b == 8'h0A) begin
      m_ptr = 6;
    end else if (b == 8'h0C) begin
      model_reset();
    end
  endtask

  // ---------------- compare process ----------------
  logic [95:0] cur_line;
  logic [3:0]  cur_ptr;
  logic [7:0]  cur_byte;
  logic        prev_valid = 1'b0;
  logic        prev_err   = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cur_line = ALL_SPACES;
        cur_ptr  = 4'd0;
        cur_byte = 8'h00;
        exp_q.delete();
        check("rst_byte_valid", byte_valid, 0);
        check("rst_frame_err", frame_err, 0);
      end else begin
        if (byte_valid) begin
          valid_cnt++;
          check("valid_gap", prev_valid, 0);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: byte_valid with byte %h, expected no pulse", byte_data);
          end else begin
            e = exp_q.pop_front();
            cur_byte = e.b;
            cur_line = e.line;
            cur_ptr  = e.ptr;
          end
        end
        if (frame_err) begin
          err_seen++;
          check("err_gap", prev_err, 0);
        end
      end
      check("line_data", line_data, cur_line);
      check("wr_ptr", wr_ptr, cur_ptr);
      check("byte_data", byte_data, cur_byte);
      prev_valid = byte_valid;
      prev_err   = frame_err;
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("tx reset");
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good, input int low_bits);
    exp_t e;
    if (good) begin
      model_apply(b);
      e.b    = b;
      e.line = m_pack();
      e.ptr  = 4'(m_ptr);
      exp_q.push_back(e);
    end else begin
      err_exp++;
    end
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    if (!good) begin
      rxd = 1'b0;
      repeat (DIV * low_bits) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (DIV) @(negedge clk);
    check("frame_latency", exp_q.size(), 0);
    check("frame_err_count", err_seen, err_exp);
    $display("tx byte %h %s", b, good ? "good" : "bad-stop");
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, 0);
  endtask

  initial begin
    int base_v;
    int base_e;
    logic [7:0] b;
    int r;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_line", line_data, ALL_SPACES);
    check("reset_ptr", wr_ptr, 0);

    // HELLO
    do_reset();
    base_v = valid_cnt;
    send_str("HELLO");
    check("hello_line", line_data, 96'h20202020202020_4F4C4C4548);
    check("hello_ptr", wr_ptr, 5);
    check("hello_pulses", valid_cnt - base_v, 5);

    // wrap after 12 printable characters
    do_reset();
    for (int c = 8'h41; c <= 8'h4D; c++) send_frame(8'(c), 1'b1, 0);
    check("wrap_line", line_data, 96'h4C4B4A4948474645444342_4D);
    check("wrap_ptr", wr_ptr, 1);

    // LF / CR cursor moves
    do_reset();
    send_str("AB");
    send_frame(8'h0A, 1'b1, 0);
    send_str("CD");
    send_frame(8'h0D, 1'b1, 0);
    send_str("X");
    check("crlf_line", line_data, 96'h20202020_4443_20202020_4258);
    check("crlf_ptr", wr_ptr, 1);

    // stop bit low, line held low three bit-times
    base_v = valid_cnt;
    base_e = err_seen;
    send_frame(8'h55, 1'b0, 3);
    check("break_one_err", err_seen - base_e, 1);
    check("break_no_valid", valid_cnt - base_v, 0);
    check("break_line", line_data, 96'h20202020_4443_20202020_4258);
    send_str("Z");
    check("after_break_line", line_data, 96'h20202020_4443_20202020_5A58);

    // short low glitch must not start a frame
    base_v = valid_cnt;
    base_e = err_seen;
    rxd = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    $display("tx glitch %0d clk", DIV / 4);
    check("glitch_no_valid", valid_cnt - base_v, 0);
    check("glitch_no_err", err_seen - base_e, 0);
    send_str("Y");
    check("after_glitch_line", line_data, 96'h20202020_4443_202020_595A58);
    check("after_glitch_ptr", wr_ptr, 3);

    // reset in the middle of bit 4
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    b = 8'h52;
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = b[4];
    repeat (DIV / 2) @(negedge clk);
    do_reset();
    check("midreset_line", line_data, ALL_SPACES);
    check("midreset_ptr", wr_ptr, 0);
    base_v = valid_cnt;
    send_str("Q");
    check("q_line", line_data, {{11{8'h20}}, 8'h51});
    send_str("HI");
    send_frame(8'h0C, 1'b1, 0);
    check("ff_line", line_data, ALL_SPACES);
    check("ff_ptr", wr_ptr, 0);
    check("ff_pulses", valid_cnt - base_v, 4);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 68) b = 8'h0D;
      else if (r < 76) b = 8'h0A;
      else if (r < 82) b = 8'h0C;
      else if (r < 91) b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h7F, 8'hFF))
                                                       : 8'($urandom_range(0, 9));
      else             b = 8'($urandom);
      if (r >= 91) send_frame(b, 1'b0, $urandom_range(1, 3));
      else         send_frame(b, 1'b1, 0);
      repeat ($urandom_range(0, DIV)) @(negedge clk);
    end
    check("final_line", line_data, m_pack());
    check("final_ptr", wr_ptr, 4'(m_ptr));
    check("final_err_total", err_seen, err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
